// File: rtl/if_id_buffer_pkg.sv
// Shared fetch-packet types and constants for the IF/ID boundary.
package if_id_pkg;

    localparam int unsigned PC_W_DEF   = 64;
    localparam int unsigned INST_W_DEF = 32;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W_DEF-1:0]   pc;
        logic [INST_W_DEF-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/if_id_buffer_wrap_ptr.sv
// Modulo-DEPTH pointer with increment and synchronous clear.
module wrap_ptr
    import if_id_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_nxt;

    always_comb begin
        ptr_nxt = ptr;
        if (clr)
            ptr_nxt = '0;
        else if (inc)
            ptr_nxt = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else
            ptr <= ptr_nxt;
    end

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling FIFO: registered handshakes, flush, NOP when empty.
module if_id_buffer
    import if_id_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned PC_W   = PC_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF,
    parameter int unsigned AW     = $clog2(DEPTH),
    parameter int unsigned CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_instr,
    output logic              in_ready,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_instr,
    input  logic              out_ready,
    input  logic              flush,
    output logic [CW-1:0]     count
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] instr;
    } pkt_t;

    pkt_t          mem [DEPTH];
    pkt_t          head;
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic          push;
    logic          pop;

    // in_ready is held low while reset is asserted, then rises with no edge
    assign in_ready  = !reset && (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    wrap_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (pop),
        .ptr   (rptr)
    );

    wrap_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (push),
        .ptr   (wptr)
    );

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= '{pc: in_pc, instr: in_instr};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (flush)
            count <= '0;
        else begin
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rptr];
    assign out_pc    = out_valid ? head.pc : '0;
    assign out_instr = out_valid ? head.instr : INST_W'(NOP);

endmodule
